// File: rtl/bird_motion_ctrl_if.sv
// Bundle of frame-control inputs, draw-engine handshake and bird status
// exchanged between the bird motion controller and its surroundings.
interface bird_motion_ctrl_if #(
  parameter int Y_W = 7,
  parameter int V_W = 5
);
  logic           tick;
  logic           press_key;
  logic           touched;
  logic           draw_done;
  logic [Y_W-1:0] bird_y;
  logic [V_W-1:0] bird_vy;
  logic           draw_req;
  logic           erase;
  logic           dead;
  logic           frame_overrun;
  logic [2:0]     state;

  // Controller side: drives the draw request and bird status.
  modport master (
    input  tick, press_key, touched, draw_done,
    output bird_y, bird_vy, draw_req, erase, dead, frame_overrun, state
  );

  // Environment side: keyboard, frame tick, pipe logic and plotter.
  modport slave (
    output tick, press_key, touched, draw_done,
    input  bird_y, bird_vy, draw_req, erase, dead, frame_overrun, state
  );
endinterface

// File: rtl/bird_motion_ctrl.sv
// Vertical motion controller for the player bird: signed velocity/gravity
// model, edge-detected flaps, ceiling/floor clamping, collision death, and
// per-frame erase/update/draw sequencing against the VGA plotter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_READY   | waiting for first flap; bird parked at Y_START, not drawn
// S_PLAY    | idle between frames; tick starts a frame, hit ends the game
// S_ERASE   | erasing bird at old row (draw_req=1, erase=1)
// S_UPDATE  | one cycle: apply flap/gravity, move and clamp
// S_DRAW    | drawing bird at new row (draw_req=1, erase=0)
// S_DEAD    | game over, bird left on screen; flap restarts
// S_ERASE_R | erasing dead bird before returning to S_READY
module bird_motion_ctrl #(
  parameter int Y_W      = 7,
  parameter int V_W      = 5,
  parameter int Y_TOP    = 0,
  parameter int Y_BOTTOM = 112,
  parameter int Y_START  = 56,
  parameter int GRAV     = 1,
  parameter int FLAP_V   = 5,
  parameter int V_MAX    = 6
) (
  input  logic               clk,
  input  logic               resetn,
  bird_motion_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_READY   = 3'd0,
    S_PLAY    = 3'd1,
    S_ERASE   = 3'd2,
    S_UPDATE  = 3'd3,
    S_DRAW    = 3'd4,
    S_DEAD    = 3'd5,
    S_ERASE_R = 3'd6
  } state_t;

  // One extra bit for the gravity sum, two extra for the row sum so that
  // both overshoot above the top and below the floor stay representable.
  localparam int VX = V_W + 1;
  localparam int YX = Y_W + 2;

  localparam logic signed [VX-1:0]  GRAV_X  = VX'(GRAV);
  localparam logic signed [VX-1:0]  VMAX_X  = VX'(V_MAX);
  localparam logic signed [V_W-1:0] VMAX_V  = V_W'(V_MAX);
  localparam logic signed [V_W-1:0] VFLAP_V = V_W'(-FLAP_V);
  localparam logic signed [YX-1:0]  YTOP_X  = YX'(Y_TOP);
  localparam logic signed [YX-1:0]  YBOT_X  = YX'(Y_BOTTOM);

  state_t                state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] vy_q, vy_d;
  logic                  press_q;
  logic                  flap_pend_q, flap_pend_d;
  logic                  hit_pend_q, hit_pend_d;
  logic                  draw_req_q, draw_req_d;
  logic                  erase_q, erase_d;
  logic                  dead_q, dead_d;
  logic                  overrun_q, overrun_d;

  logic                  flap_edge;
  logic                  in_frame;
  logic signed [VX-1:0]  vy_inc;
  logic signed [V_W-1:0] vy_n;
  logic signed [YX-1:0]  y_n;

  assign flap_edge = bus.press_key & ~press_q;
  assign in_frame  = (state_q == S_PLAY) || (state_q == S_ERASE) ||
                     (state_q == S_UPDATE) || (state_q == S_DRAW);

  // Candidate velocity and row for the update step.
  always_comb begin
    vy_inc = {vy_q[V_W-1], vy_q} + GRAV_X;
    vy_n   = vy_inc[V_W-1:0];
    if (flap_pend_q) begin
      vy_n = VFLAP_V;
    end else if (vy_inc > VMAX_X) begin
      vy_n = VMAX_V;
    end
    y_n = $signed({2'b00, y_q}) + $signed({{(YX-V_W){vy_n[V_W-1]}}, vy_n});
  end

  // Next-state, motion update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    vy_d        = vy_q;
    flap_pend_d = flap_pend_q | (in_frame & flap_edge);
    hit_pend_d  = hit_pend_q  | (in_frame & bus.touched);

    case (state_q)
      S_READY: begin
        if (flap_edge) state_d = S_DRAW;
      end
      S_PLAY: begin
        if (hit_pend_q)    state_d = S_DEAD;
        else if (bus.tick) state_d = S_ERASE;
      end
      S_ERASE: begin
        if (bus.draw_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // Pending flap is consumed; an edge landing this very cycle counts
        // toward the next frame.
        flap_pend_d = flap_edge;
        if (y_n <= YTOP_X) begin
          y_d  = Y_W'(Y_TOP);
          vy_d = '0;
        end else if (y_n >= YBOT_X) begin
          y_d        = Y_W'(Y_BOTTOM);
          vy_d       = '0;
          hit_pend_d = 1'b1;
        end else begin
          y_d  = y_n[Y_W-1:0];
          vy_d = vy_n;
        end
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (bus.draw_done) state_d = (hit_pend_q | bus.touched) ? S_DEAD : S_PLAY;
      end
      S_DEAD: begin
        if (flap_edge) state_d = S_ERASE_R;
      end
      S_ERASE_R: begin
        if (bus.draw_done) begin
          y_d     = Y_W'(Y_START);
          vy_d    = '0;
          state_d = S_READY;
        end
      end
      default: state_d = S_READY;
    endcase

    if (state_d == S_READY && state_q != S_READY) hit_pend_d = 1'b0;

    draw_req_d = (state_d == S_ERASE) || (state_d == S_DRAW) || (state_d == S_ERASE_R);
    erase_d    = (state_d == S_ERASE) || (state_d == S_ERASE_R);
    dead_d     = (state_d == S_DEAD);
    overrun_d  = bus.tick & (state_q != S_PLAY);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_READY;
      y_q         <= Y_W'(Y_START);
      vy_q        <= '0;
      press_q     <= 1'b0;
      flap_pend_q <= 1'b0;
      hit_pend_q  <= 1'b0;
      draw_req_q  <= 1'b0;
      erase_q     <= 1'b0;
      dead_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      press_q     <= bus.press_key;
      flap_pend_q <= flap_pend_d;
      hit_pend_q  <= hit_pend_d;
      draw_req_q  <= draw_req_d;
      erase_q     <= erase_d;
      dead_q      <= dead_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.bird_y        = y_q;
  assign bus.bird_vy       = vy_q;
  assign bus.draw_req      = draw_req_q;
  assign bus.erase         = erase_q;
  assign bus.dead          = dead_q;
  assign bus.frame_overrun = overrun_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Scoreboard bench for bird_motion_ctrl: every accepted draw handshake is
// popped from an expected-value queue by an independent monitor.
module tb_bird_motion_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bird_motion_ctrl_if #(.Y_W(7), .V_W(5)) bus();

  bird_motion_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    bit er;
    int y;
    int vy;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int checks = 0;
  int errors = 0;
  int my, mvy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake is accepted when draw_req and draw_done are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.draw_req === 1'b1 && bus.draw_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_draw: erase=%b y=%0d with empty queue", bus.erase, bus.bird_y);
        end else begin
          e_mon = sb.pop_front();
          chk("draw_erase", int'(bus.erase), int'(e_mon.er));
          chk("draw_y", int'(bus.bird_y), e_mon.y);
          chk("draw_vy", int'($signed(bus.bird_vy)), e_mon.vy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_press();
    bus.press_key = 1'b1;
    cyc(1);
    bus.press_key = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  task automatic wait_req();
    int t = 0;
    while (bus.draw_req !== 1'b1 && t < 100) begin
      cyc(1);
      t++;
    end
    if (bus.draw_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL draw_req_timeout: draw_req=%b expected 1", bus.draw_req);
    end
  endtask

  task automatic ack_rest(input int d);
    repeat (d) begin
      cyc(1);
      chk("req_held", int'(bus.draw_req), 1);
    end
    bus.draw_done = 1'b1;
    cyc(1);
    bus.draw_done = 1'b0;
    chk("req_drop", int'(bus.draw_req), 0);
  endtask

  task automatic frame(input bit flap, input bit touch, input int ey, input int evy);
    if (flap) pulse_press();
    sb.push_back('{1'b1, my, mvy});
    pulse_tick();
    wait_req();
    if (touch) begin
      bus.touched = 1'b1;
      cyc(1);
      bus.touched = 1'b0;
    end
    ack_rest(2);
    sb.push_back('{1'b0, ey, evy});
    wait_req();
    ack_rest(1);
    my  = ey;
    mvy = evy;
  endtask

  // Reference motion step used for the long climb/fall sequences.
  task automatic step(input bit flap);
    int nv, t, ny, nvy;
    if (flap) nv = -5;
    else nv = (mvy + 1 > 6) ? 6 : mvy + 1;
    t = my + nv;
    if (t <= 0) begin
      ny = 0; nvy = 0;
    end else if (t >= 112) begin
      ny = 112; nvy = 0;
    end else begin
      ny = t; nvy = nv;
    end
    frame(flap, 1'b0, ny, nvy);
  endtask

  initial begin
    int n;
    bus.tick = 1'b0;
    bus.press_key = 1'b0;
    bus.touched = 1'b0;
    bus.draw_done = 1'b0;
    #12;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_y", int'(bus.bird_y), 56);
    chk("rst_vy", int'(bus.bird_vy), 0);
    chk("rst_req", int'(bus.draw_req), 0);
    chk("rst_dead", int'(bus.dead), 0);
    chk("rst_overrun", int'(bus.frame_overrun), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1);
    my = 56;
    mvy = 0;

    // First flap: initial plot at the start row.
    sb.push_back('{1'b0, 56, 0});
    pulse_press();
    wait_req();
    ack_rest(3);
    chk("play_after_start", int'(bus.state), 1);

    // Stray draw_done in S_PLAY.
    bus.draw_done = 1'b1;
    cyc(1);
    bus.draw_done = 1'b0;
    chk("stray_done_play_state", int'(bus.state), 1);
    chk("stray_done_play_req", int'(bus.draw_req), 0);

    // Free fall, hand-computed.
    frame(1'b0, 1'b0, 57, 1);
    frame(1'b0, 1'b0, 59, 2);
    frame(1'b0, 1'b0, 62, 3);

    // Two edges in one frame collapse to a single flap.
    pulse_press();
    pulse_press();
    frame(1'b0, 1'b0, 57, -5);
    frame(1'b0, 1'b0, 53, -4);

    // Flap every frame until the ceiling clamps.
    for (int i = 0; i < 11; i++) begin
      step(1'b1);
      chk("ceiling_not_dead", int'(bus.dead), 0);
    end
    chk("ceiling_y", int'(bus.bird_y), 0);
    chk("ceiling_vy", int'(bus.bird_vy), 0);

    // Fall to the floor with velocity saturating at terminal speed.
    n = 0;
    while (my != 112 && n < 40) begin
      step(1'b0);
      checks++;
      if ($signed(bus.bird_vy) > 6) begin
        errors++;
        $display("FAIL vy_sat: got %0d expected <= 6", $signed(bus.bird_vy));
      end
      n++;
    end
    chk("floor_dead", int'(bus.dead), 1);
    chk("floor_state", int'(bus.state), 5);
    chk("floor_y", int'(bus.bird_y), 112);

    // Tick while dead: one-cycle overrun pulse, no state change.
    pulse_tick();
    chk("overrun_pulse", int'(bus.frame_overrun), 1);
    cyc(1);
    chk("overrun_clear", int'(bus.frame_overrun), 0);
    chk("overrun_state", int'(bus.state), 5);

    // Stray draw_done in S_DEAD.
    bus.draw_done = 1'b1;
    cyc(1);
    bus.draw_done = 1'b0;
    chk("stray_done_dead_state", int'(bus.state), 5);
    chk("stray_done_dead_req", int'(bus.draw_req), 0);

    // Restart: erase at the floor, back to READY at the start row.
    sb.push_back('{1'b1, 112, 0});
    pulse_press();
    wait_req();
    ack_rest(2);
    chk("restart_state", int'(bus.state), 0);
    chk("restart_y", int'(bus.bird_y), 56);
    chk("restart_vy", int'(bus.bird_vy), 0);
    chk("restart_dead", int'(bus.dead), 0);
    my = 56;
    mvy = 0;

    // Same-cycle ack, then collision during erase: frame completes, then dead.
    sb.push_back('{1'b0, 56, 0});
    pulse_press();
    wait_req();
    ack_rest(0);
    chk("play_after_restart", int'(bus.state), 1);
    frame(1'b0, 1'b1, 57, 1);
    chk("touch_dead", int'(bus.dead), 1);
    chk("touch_state", int'(bus.state), 5);
    chk("touch_y", int'(bus.bird_y), 57);

    // Restart, then reset asynchronously mid-draw.
    sb.push_back('{1'b1, 57, 1});
    pulse_press();
    wait_req();
    ack_rest(1);
    chk("restart2_state", int'(bus.state), 0);
    pulse_press();
    wait_req();
    chk("pre_rst_state", int'(bus.state), 4);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_req", int'(bus.draw_req), 0);
    chk("async_rst_state", int'(bus.state), 0);
    chk("async_rst_y", int'(bus.bird_y), 56);
    chk("async_rst_vy", int'(bus.bird_vy), 0);
    cyc(1);
    resetn = 1'b1;
    cyc(2);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
- Parametrised vertical-motion controller for the player bird.
- Replaces the fixed raise/fall FSM with a signed velocity/gravity model, edge-detected flaps, ceiling/floor clamping and collision-driven death.
- Sequences each frame as erase-old, update, draw-new against the VGA draw engine through a req/done handshake.
- Sits between keyboard/frame-tick logic and the pixel plotter; pipe logic supplies `touched`.

Parameters:
- Y_W, 7, width of bird_y (unsigned pixel row).
- V_W, 5, width of bird_vy (two's complement, rows per frame; positive = down).
- Y_TOP, 0, topmost legal row.
- Y_BOTTOM, 112, floor row; reaching it is death.
- Y_START, 56, row loaded on reset and on restart.
- GRAV, 1, velocity increment per frame.
- FLAP_V, 5, velocity magnitude after a flap (vy := -FLAP_V).
- V_MAX, 6, terminal fall velocity.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, asynchronous active-low reset.
- tick, input, 1, one-cycle frame pulse.
- press_key, input, 1, flap button level.
- touched, input, 1, pipe collision level.
- draw_done, input, 1, one-cycle pulse from plotter when the requested draw finishes.
- bird_y, output, Y_W, current bird row.
- bird_vy, output, V_W, current velocity.
- draw_req, output, 1, plot request, held high until draw_done.
- erase, output, 1, qualifies draw_req: 1 = erase at bird_y, 0 = draw at bird_y.
- dead, output, 1, high in S_DEAD.
- frame_overrun, output, 1, one-cycle pulse when tick arrives outside S_PLAY.
- state, output, 3, current FSM state for debug.

Behaviour:
- Reset (async, resetn=0):
  - state=S_READY, bird_y=Y_START, bird_vy=0.
  - draw_req, erase, dead, frame_overrun, flap_pend, hit_pend, press_q all 0.
- Flap edge: press_q<=press_key each cycle; flap_edge = press_key & ~press_q.
- flap_pend:
  - Sets on flap_edge in S_PLAY/S_ERASE/S_UPDATE/S_DRAW; cleared in S_UPDATE.
  - Multiple edges within one frame collapse to one flap.
- hit_pend: sets on touched in the same four states; cleared on entry to S_READY.
- States:
  - S_READY: on flap_edge, go to S_DRAW (initial plot at Y_START). flap_pend is not set by this edge.
  - S_PLAY: idle. On tick go to S_ERASE. If hit_pend, go to S_DEAD (priority over tick).
  - S_ERASE: draw_req=1, erase=1. On draw_done go to S_UPDATE.
  - S_UPDATE (exactly one cycle):
    - vy_n = flap_pend ? -FLAP_V : min(vy+GRAV, V_MAX).
    - y_n = y + vy_n, computed signed in Y_W+2 bits.
    - If y_n <= Y_TOP: y=Y_TOP, vy=0 (ceiling is not death).
    - If y_n >= Y_BOTTOM: y=Y_BOTTOM, vy=0, hit_pend=1.
    - Otherwise y=y_n, vy=vy_n.
    - Next state: S_DRAW.
  - S_DRAW: draw_req=1, erase=0. On draw_done go to S_DEAD if hit_pend, else S_PLAY.
  - S_DEAD: dead=1; bird remains drawn. On flap_edge go to S_ERASE_R.
  - S_ERASE_R: draw_req=1, erase=1. On draw_done: y=Y_START, vy=0, hit_pend=0, go to S_READY.
- Handshake:
  - draw_req/erase are registered and stable until the cycle draw_done is sampled high; draw_req drops the following cycle.
  - draw_done while draw_req=0 is ignored.
  - draw_done in the same cycle draw_req first rises is accepted.
- touched arriving mid-frame does not abort a handshake: the current frame completes, then the FSM enters S_DEAD.
- tick outside S_PLAY is dropped, not queued, and frame_overrun pulses for one cycle.
- An illegal state encoding recovers to S_READY on the next clock.
- Asserting resetn mid-handshake clears draw_req immediately, asynchronously.

Test Plan:
- Reset with resetn=0 while in S_DRAW with draw_req=1 -> draw_req=0 without a clock edge; bird_y=56, bird_vy=0, state=S_READY.
- Press from READY, draw_done after 3 cycles, then 3 ticks with no press, each handshake acked -> bird_vy 1,2,3; bird_y 57,59,62; each frame shows erase=1 then erase=0 with draw_req held until draw_done.
- From y=62, vy=3: two press edges before one tick -> single flap, bird_vy=-5, bird_y=57; next tick without press -> vy=-4, y=53.
- Start at y=3, press each frame -> y clamps to 0, vy=0, dead stays 0; no presses -> vy saturates at 6 and never exceeds it.
- Fall to floor, or assert touched during S_ERASE -> current S_DRAW completes at y≤112, then dead=1; a tick in S_DEAD gives a one-cycle frame_overrun; a press gives an erase handshake, then S_READY with y=56.
- draw_done pulsed in S_PLAY or S_DEAD -> no state change and no draw_req.
